seven_seg_scan_driver: RTL and testbench

- Time-multiplexed driver for a common-anode multi-digit seven-segment display. Generalises the team's single-digit hex decoder: NUM_DIGITS digits, per-digit decimal point, per-digit blanking, leading-zero suppression, PWM brightness, and tear-free double-buffered update.
- Sits between the register or datapath that produces a packed hex value and the board's segment and anode pins.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/hex_to_seg.sv | 8 +
 rtl/seven_seg_scan_driver.sv | 105 ++++++++++
 tb/tb_seven_seg_scan_driver.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: active-low glyph constants and sizing helper for the scan driver
package seven_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h0C;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h60;
  localparam logic [6:0] GLYPH_C = 7'h31;
  localparam logic [6:0] GLYPH_D = 7'h42;
  localparam logic [6:0] GLYPH_E = 7'h30;
  localparam logic [6:0] GLYPH_F = 7'h38;
  localparam logic [15:0][6:0] GLYPH_ROM = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: nibble to active-low seven-segment glyph lookup
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;
  assign seg = GLYPH_ROM[nibble];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode display scanner with PWM and double buffering
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 100000,
  parameter int DUTY_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [4*NUM_DIGITS-1:0] display_info,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic lz_blank,
  input  logic load,
  input  logic [DUTY_BITS-1:0] brightness,
  output logic [6:0] seg,
  output logic dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic frame_done
);
  import seven_seg_pkg::*;
  localparam int PW = width_of(CLK_DIV);
  localparam int IW = width_of(NUM_DIGITS);
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [DUTY_BITS-1:0] pwm;
  logic [NUM_DIGITS-1:0][3:0] pend_nib, sh_nib;
  logic [NUM_DIGITS-1:0] pend_dp, pend_mask, sh_dp, sh_mask, lz_dark, sel;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic pending, slot_end, boundary, active;
  assign slot_end = presc == PW'(CLK_DIV - 1);
  assign boundary = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign sel = NUM_DIGITS'(1) << idx;
  assign active = presc != '0 && pwm < brightness && !(|(sel & (sh_mask | lz_dark)));
  // digit i is dark when it and every digit above it holds zero
  always_comb begin
    logic zeros;
    zeros = 1'b1;
    lz_dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros = zeros & (sh_nib[i] == 4'h0);
      lz_dark[i] = lz_blank & zeros;
    end
  end
  // pick the shadow nibble of the digit currently being scanned
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) nib = sel[i] ? sh_nib[i] : nib;
  end
  hex_to_seg u_dec (.nibble(nib), .seg(glyph));
  // slot prescaler, digit index and free-running pwm counter
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      idx <= boundary ? '0 : slot_end ? idx + 1'b1 : idx;
      pwm <= pwm + 1'b1;
    end
  end
  // pending buffer collects loads; shadow only changes at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pend_nib <= '0;
      pend_dp <= '0;
      pend_mask <= '0;
      sh_nib <= '0;
      sh_dp <= '0;
      sh_mask <= '0;
    end else if (boundary) begin
      pending <= 1'b0;
      if (load) begin
        sh_nib <= display_info;
        sh_dp <= dp_in;
        sh_mask <= blank_mask;
      end else if (pending) begin
        sh_nib <= pend_nib;
        sh_dp <= pend_dp;
        sh_mask <= pend_mask;
      end
    end else if (load) begin
      pending <= 1'b1;
      pend_nib <= display_info;
      pend_dp <= dp_in;
      pend_mask <= blank_mask;
    end
  end
  // registered pin drive, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      dp <= 1'b1;
      an <= '1;
      frame_done <= 1'b0;
    end else begin
      seg <= active ? glyph : SEG_BLANK;
      dp <= ~(active & |(sh_dp & sel));
      an <= active ? ~sel : '1;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboarded bench for the seven-segment scan driver
module tb_seven_seg_scan_driver;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic fd;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, lz_blank = 1'b0, load = 1'b0;
  logic [15:0] display_info = '0;
  logic [3:0] dp_in = '0, blank_mask = '0;
  logic [1:0] brightness = '0;
  logic [6:0] seg, seg1;
  logic dp, frame_done, dp1, frame_done1;
  logic [3:0] an;
  logic [0:0] an1;
  int compared = 0, mismatched = 0;
  exp_t q[$];
  logic [6:0] gl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                          7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [1:0] m_presc, m_idx, m_pwm;
  logic [15:0] m_nib, p_nib;
  logic [3:0] m_dp, m_mask, p_dp, p_mask;
  logic m_pend;
  wire [12:0] obs = {an, seg, dp, frame_done};
  seven_seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .DUTY_BITS(2)) dut (
    .clk(clk), .reset(reset), .display_info(display_info), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank), .load(load), .brightness(brightness),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));
  seven_seg_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(4), .DUTY_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .display_info(display_info[3:0]), .dp_in(dp_in[0]),
    .blank_mask(blank_mask[0]), .lz_blank(lz_blank), .load(load), .brightness(brightness),
    .seg(seg1), .dp(dp1), .an(an1), .frame_done(frame_done1));
  always #5 clk = ~clk;
  function automatic exp_t model_out();
    logic act, lz;
    if (reset) return '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    lz = lz_blank && m_idx != 0 && (m_nib >> (4 * m_idx)) == 16'h0;
    act = m_presc != 0 && m_pwm < brightness && !m_mask[m_idx] && !lz;
    return '{an: act ? ~(4'b1 << m_idx) : 4'hF, seg: act ? gl[m_nib[4*m_idx +: 4]] : 7'h7F,
             dp: act ? ~m_dp[m_idx] : 1'b1, fd: m_presc == 3 && m_idx == 3};
  endfunction
  always @(posedge clk) begin
    q.push_back(model_out());
    if (reset) begin
      {m_presc, m_idx, m_pwm, m_nib, p_nib, m_dp, m_mask, p_dp, p_mask, m_pend} <= '0;
    end else begin
      m_presc <= m_presc + 1'b1;
      m_pwm <= m_pwm + 1'b1;
      if (m_presc == 3) m_idx <= m_idx + 1'b1;
      if (m_presc == 3 && m_idx == 3) begin
        m_pend <= 1'b0;
        if (load) {m_nib, m_dp, m_mask} <= {display_info, dp_in, blank_mask};
        else if (m_pend) {m_nib, m_dp, m_mask} <= {p_nib, p_dp, p_mask};
      end else if (load) begin
        {p_nib, p_dp, p_mask} <= {display_info, dp_in, blank_mask};
        m_pend <= 1'b1;
      end
    end
  end
  task automatic tick(output exp_t e);
    @(negedge clk);
    e = (q.size() != 0) ? q.pop_front() : 13'bx;
  endtask
  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    repeat (3) begin
      tick(e);
      compared++;
      if (obs !== e || obs !== 13'h1FFE) begin
        mismatched++;
        $display("FAIL reset_state got=%h exp=%h", obs, 13'h1FFE);
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_basic();
    exp_t e;
    logic [6:0] seg_exp [4] = '{7'h38, 7'h08, 7'h12, 7'h4F};
    int n = 0;
    display_info = 16'h12AF;
    brightness = 2'd3;
    load = 1'b1;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL basic_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    compared++;
    if (!frame_done) begin mismatched++; $display("FAIL basic_frame_timeout got=0 exp=1"); end
    for (int c = 0; c < 16; c++) begin
      logic lit;
      tick(e);
      lit = c % 4 == 1 || c % 4 == 2;
      compared++;
      if (obs !== e || an !== (lit ? ~(4'b1 << (c / 4)) : 4'hF) || (lit && seg !== seg_exp[c/4])) begin
        mismatched++;
        $display("FAIL basic_scan c=%0d got an=%b seg=%b exp_sb=%h", c, an, seg, e);
      end
    end
  endtask
  task automatic test_lz();
    exp_t e;
    int n = 0, seen5 = 0;
    lz_blank = 1'b1;
    display_info = 16'h0050;
    load = 1'b1;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL lz_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 16; c++) begin
      tick(e);
      if (an == 4'b1101 && seg == 7'h24) seen5++;
      compared++;
      if (obs !== e || an[3] !== 1'b1 || an[2] !== 1'b1 || (an == 4'b1110 && seg !== 7'h01)) begin
        mismatched++;
        $display("FAIL lz_0050 got an=%b seg=%h exp_sb=%h", an, seg, e);
      end
    end
    compared++;
    if (seen5 != 2) begin mismatched++; $display("FAIL lz_digit1 got=%0d exp=2", seen5); end
    display_info = 16'h0000;
    load = 1'b1;
    n = 0;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL lz_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 16; c++) begin
      tick(e);
      compared++;
      if (obs !== e || (an !== 4'hF && (an !== 4'b1110 || seg !== 7'h01))) begin
        mismatched++;
        $display("FAIL lz_0000 got an=%b seg=%h exp_sb=%h", an, seg, e);
      end
    end
    lz_blank = 1'b0;
  endtask
  task automatic test_tear();
    exp_t e;
    int n = 0, lit = 0;
    display_info = 16'h3333;
    load = 1'b1;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL tear_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 7; c++) begin
      display_info = c == 5 ? 16'h1111 : 16'h2222;
      load = c >= 5;
      tick(e);
      compared++;
      if (obs !== e || (an !== 4'hF && seg !== 7'h06)) begin
        mismatched++;
        $display("FAIL tear_old got seg=%h exp=%h", seg, 7'h06);
      end
    end
    load = 1'b0;
    n = 0;
    do begin
      tick(e);
      compared++;
      if (obs !== e || (an !== 4'hF && seg !== 7'h06)) begin
        mismatched++;
        $display("FAIL tear_old got seg=%h exp=%h", seg, 7'h06);
      end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 16; c++) begin
      tick(e);
      if (an !== 4'hF) lit++;
      compared++;
      if (obs !== e || (an !== 4'hF && seg !== 7'h12)) begin
        mismatched++;
        $display("FAIL tear_new got seg=%h exp=%h", seg, 7'h12);
      end
    end
    compared++;
    if (lit != 8) begin mismatched++; $display("FAIL tear_lit got=%0d exp=8", lit); end
  endtask
  task automatic test_mask_dp();
    exp_t e;
    int n = 0;
    display_info = 16'h8888;
    blank_mask = 4'b0101;
    dp_in = 4'b1000;
    load = 1'b1;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL mask_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 16; c++) begin
      tick(e);
      compared++;
      if (obs !== e || an[0] !== 1'b1 || an[2] !== 1'b1 || (dp === 1'b0) !== (an === 4'b0111)) begin
        mismatched++;
        $display("FAIL mask_dp got an=%b dp=%b exp_sb=%h", an, dp, e);
      end
    end
    blank_mask = '0;
    dp_in = '0;
  endtask
  task automatic test_brightness();
    exp_t e;
    int n = 0, lit = 0;
    brightness = 2'd0;
    load = 1'b1;
    for (int c = 0; c < 48; c++) begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e || an !== 4'hF) begin
        mismatched++;
        $display("FAIL bright0 got an=%b exp=1111", an);
      end
    end
    brightness = 2'd2;
    do begin
      tick(e);
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL bright_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 16; c++) begin
      tick(e);
      if (an !== 4'hF) lit++;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL bright2_sb got=%h exp=%h", obs, e); end
    end
    compared++;
    if (lit != 4) begin mismatched++; $display("FAIL bright2_lit got=%0d exp=4", lit); end
    brightness = 2'd3;
  endtask
  task automatic test_reset_mid();
    exp_t e;
    int n = 0;
    display_info = 16'h4444;
    load = 1'b1;
    do begin
      tick(e);
      load = 1'b0;
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL rmid_sb got=%h exp=%h", obs, e); end
      n++;
    end while (!frame_done && n < 64);
    for (int c = 0; c < 9; c++) begin
      display_info = 16'h9999;
      load = c == 6;
      reset = c == 8;
      tick(e);
      compared++;
      if (obs !== e || (c == 8 && (an !== 4'hF || seg !== 7'h7F))) begin
        mismatched++;
        $display("FAIL rmid_reset c=%0d got an=%b seg=%h exp_sb=%h", c, an, seg, e);
      end
    end
    load = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(e);
      compared++;
      if (obs !== e || (an !== 4'hF && seg !== 7'h01)) begin
        mismatched++;
        $display("FAIL rmid_zero got seg=%h exp=%h", seg, 7'h01);
      end
    end
  endtask
  task automatic test_single();
    exp_t e;
    int n = 0;
    do begin
      tick(e);
      n++;
    end while (!frame_done1 && n < 16);
    compared++;
    if (!frame_done1) begin mismatched++; $display("FAIL single_timeout got=0 exp=1"); end
    for (int k = 1; k <= 12; k++) begin
      tick(e);
      compared++;
      if (obs !== e || frame_done1 !== (k % 4 == 0)) begin
        mismatched++;
        $display("FAIL single_fd k=%0d got=%b exp=%b", k, frame_done1, k % 4 == 0);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_tear();
    test_mask_dp();
    test_brightness();
    test_reset_mid();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
